// File: rtl/lfsr_prbs_engine.sv
// Maximal-length XNOR Fibonacci LFSR generator with seed load and period flag, plus a
// self-synchronising PRBS checker (same polynomial) with lock tracking and error counting.
module lfsr_prbs_engine #(
  parameter int unsigned NUM_BITS   = 8,
  parameter int unsigned LOCK_COUNT = 16,
  parameter int unsigned LOSS_COUNT = 4,
  parameter int unsigned ERR_W      = 16
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_Enable,
  input  logic                i_Seed_DV,
  input  logic [NUM_BITS-1:0] i_Seed_Data,
  output logic [NUM_BITS-1:0] o_LFSR_Data,
  output logic                o_LFSR_Bit,
  output logic                o_LFSR_Done,
  output logic                o_Seed_Err,
  input  logic                i_Chk_Valid,
  input  logic                i_Chk_Bit,
  output logic                o_Chk_Locked,
  output logic                o_Chk_Err,
  output logic [ERR_W-1:0]    o_Chk_Err_Cnt
);

  // Bit i of the mask set means tap i+1 feeds the XNOR.
  function automatic logic [15:0] tap_mask(input int unsigned n);
    logic [15:0] m;
    m = '0;
    case (n)
      3:       m = 16'h0006;
      4:       m = 16'h000C;
      5:       m = 16'h0014;
      6:       m = 16'h0030;
      7:       m = 16'h0060;
      8:       m = 16'h00B8;
      9:       m = 16'h0110;
      10:      m = 16'h0240;
      11:      m = 16'h0500;
      12:      m = 16'h0829;
      13:      m = 16'h100D;
      14:      m = 16'h2015;
      15:      m = 16'h6000;
      16:      m = 16'hD008;
      default: m = '0;
    endcase
    return m;
  endfunction

  if (NUM_BITS < 3 || NUM_BITS > 16) begin : g_bad_num_bits
    $error("lfsr_prbs_engine: NUM_BITS must be in 3..16");
  end
  if (LOCK_COUNT < 1 || LOSS_COUNT < 1 || ERR_W < 1) begin : g_bad_counts
    $error("lfsr_prbs_engine: LOCK_COUNT, LOSS_COUNT and ERR_W must be nonzero");
  end

  localparam logic [15:0]         TapMask16 = tap_mask(NUM_BITS);
  localparam logic [NUM_BITS-1:0] TapMask   = TapMask16[NUM_BITS-1:0];
  localparam int unsigned         FillW     = $clog2(NUM_BITS);
  localparam int unsigned         GoodW     = $clog2(LOCK_COUNT + 1);
  localparam int unsigned         BadW      = $clog2(LOSS_COUNT + 1);

  // ---------------------------------------------------------------------------
  // Generator
  // ---------------------------------------------------------------------------
  logic [NUM_BITS-1:0] lfsr_q, start_q;
  logic [NUM_BITS-1:0] lfsr_step, seed_fixed;
  logic                seed_is_lockup;
  logic                done_q, seed_err_q;

  always_comb begin
    lfsr_step      = {lfsr_q[NUM_BITS-2:0], ~^(lfsr_q & TapMask)};
    seed_is_lockup = &i_Seed_Data;
    // All-ones is the XNOR lock-up state, so it can never be loaded.
    seed_fixed     = seed_is_lockup ? '0 : i_Seed_Data;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      lfsr_q     <= '0;
      start_q    <= '0;
      done_q     <= 1'b0;
      seed_err_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      seed_err_q <= 1'b0;
      if (i_Seed_DV) begin
        lfsr_q     <= seed_fixed;
        start_q    <= seed_fixed;
        seed_err_q <= seed_is_lockup;
      end else if (i_Enable) begin
        lfsr_q <= lfsr_step;
        done_q <= (lfsr_step == start_q);
      end
    end
  end

  assign o_LFSR_Data = lfsr_q;
  assign o_LFSR_Bit  = lfsr_q[0];
  assign o_LFSR_Done = done_q;
  assign o_Seed_Err  = seed_err_q;

  // ---------------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {StFill, StSearch, StLocked} chk_state_e;

  chk_state_e          chk_state_q;
  logic [NUM_BITS-1:0] hist_q;
  logic [FillW-1:0]    fill_q;
  logic [GoodW-1:0]    good_q;
  logic [BadW-1:0]     bad_q;
  logic                chk_err_q;
  logic [ERR_W-1:0]    err_cnt_q;
  logic                chk_match;

  assign chk_match = (i_Chk_Bit == ~^(hist_q & TapMask));

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      chk_state_q <= StFill;
      hist_q      <= '0;
      fill_q      <= '0;
      good_q      <= '0;
      bad_q       <= '0;
      chk_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      chk_err_q <= 1'b0;
      if (i_Chk_Valid) begin
        hist_q <= {hist_q[NUM_BITS-2:0], i_Chk_Bit};
        case (chk_state_q)
          StFill: begin
            if (fill_q == FillW'(NUM_BITS - 1)) begin
              chk_state_q <= StSearch;
              fill_q      <= '0;
            end else begin
              fill_q <= fill_q + 1'b1;
            end
          end
          StSearch: begin
            if (!chk_match) begin
              good_q <= '0;
            end else if (good_q == GoodW'(LOCK_COUNT - 1)) begin
              chk_state_q <= StLocked;
              good_q      <= '0;
            end else begin
              good_q <= good_q + 1'b1;
            end
          end
          StLocked: begin
            if (chk_match) begin
              bad_q <= '0;
            end else begin
              chk_err_q <= 1'b1;
              if (!(&err_cnt_q)) err_cnt_q <= err_cnt_q + 1'b1;
              // The mismatch that drops lock is still reported and counted.
              if (bad_q == BadW'(LOSS_COUNT - 1)) begin
                chk_state_q <= StSearch;
                bad_q       <= '0;
                good_q      <= '0;
              end else begin
                bad_q <= bad_q + 1'b1;
              end
            end
          end
          default: chk_state_q <= StFill;
        endcase
      end
    end
  end

  assign o_Chk_Locked  = (chk_state_q == StLocked);
  assign o_Chk_Err     = chk_err_q;
  assign o_Chk_Err_Cnt = err_cnt_q;

endmodule

// File: tb/tb_lfsr_prbs_engine.sv
// Scoreboard bench: a 4-bit generator instance and an 8-bit generator/checker instance
// (4-bit error counter) are stepped against a bench-side reference model.
module tb_lfsr_prbs_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       en4 = 1'b0, sdv4 = 1'b0;
  logic [3:0] sd4 = 4'h0;
  logic       en8 = 1'b0, cv8 = 1'b0, cb8 = 1'b0;

  logic [3:0]  d4;
  logic        bit4, done4, serr4, lk4, cerr4;
  logic [15:0] cnt4;
  logic [7:0]  d8;
  logic        bit8, done8, serr8, lk8, cerr8;
  logic [3:0]  cnt8;

  lfsr_prbs_engine #(.NUM_BITS(4)) u_dut4 (
    .i_Clk(clk), .i_Rst(rst), .i_Enable(en4), .i_Seed_DV(sdv4), .i_Seed_Data(sd4),
    .o_LFSR_Data(d4), .o_LFSR_Bit(bit4), .o_LFSR_Done(done4), .o_Seed_Err(serr4),
    .i_Chk_Valid(1'b0), .i_Chk_Bit(1'b0), .o_Chk_Locked(lk4), .o_Chk_Err(cerr4),
    .o_Chk_Err_Cnt(cnt4)
  );

  lfsr_prbs_engine #(.NUM_BITS(8), .ERR_W(4)) u_dut8 (
    .i_Clk(clk), .i_Rst(rst), .i_Enable(en8), .i_Seed_DV(1'b0), .i_Seed_Data(8'h00),
    .o_LFSR_Data(d8), .o_LFSR_Bit(bit8), .o_LFSR_Done(done8), .o_Seed_Err(serr8),
    .i_Chk_Valid(cv8), .i_Chk_Bit(cb8), .o_Chk_Locked(lk8), .o_Chk_Err(cerr8),
    .o_Chk_Err_Cnt(cnt8)
  );

  typedef struct packed {
    logic [3:0] d4;
    logic       done4, serr4;
    logic [7:0] d8;
    logic       done8, lk, cerr;
    logic [3:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state.
  logic [3:0] m_g4 = '0, m_st4 = '0;
  logic       m_done4 = 1'b0, m_serr4 = 1'b0, m_done8 = 1'b0, m_cerr = 1'b0;
  logic [7:0] m_g8 = '0, m_h = '0;
  logic [3:0] m_cnt = '0;
  int         m_cst = 0, m_fill = 0, m_good = 0, m_bad = 0;
  int         mode8 = 0;  // 0 loopback, 1 invert one bit, 2 always-wrong bit

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic fb8(input logic [7:0] s);
    return ~(s[7] ^ s[5] ^ s[4] ^ s[3]);
  endfunction

  task automatic step();
    exp_t       e;
    logic       m;
    logic [3:0] v4;
    logic [7:0] ns8;
    if (mode8 == 2)      cb8 = ~fb8(m_h);
    else if (mode8 == 1) cb8 = ~m_g8[0];
    else                 cb8 = m_g8[0];
    m_done4 = 1'b0; m_serr4 = 1'b0; m_done8 = 1'b0; m_cerr = 1'b0;
    if (rst) begin
      m_g4 = '0; m_st4 = '0; m_g8 = '0; m_h = '0; m_cnt = '0;
      m_cst = 0; m_fill = 0; m_good = 0; m_bad = 0;
    end else begin
      if (sdv4) begin
        v4 = (sd4 == 4'hF) ? 4'h0 : sd4;
        m_serr4 = (sd4 == 4'hF);
        m_g4 = v4; m_st4 = v4;
      end else if (en4) begin
        m_g4 = {m_g4[2:0], ~(m_g4[3] ^ m_g4[2])};
        m_done4 = (m_g4 == m_st4);
      end
      if (en8) begin
        ns8 = {m_g8[6:0], fb8(m_g8)};
        m_done8 = (ns8 == 8'h00);
        m_g8 = ns8;
      end
      if (cv8) begin
        m = (cb8 == fb8(m_h));
        m_h = {m_h[6:0], cb8};
        case (m_cst)
          0: if (m_fill == 7) begin m_cst = 1; m_fill = 0; end else m_fill++;
          1: if (!m) m_good = 0;
             else if (m_good == 15) begin m_cst = 2; m_good = 0; end
             else m_good++;
          default: begin
            if (m) m_bad = 0;
            else begin
              m_cerr = 1'b1;
              if (m_cnt != 4'hF) m_cnt++;
              if (m_bad == 3) begin m_cst = 1; m_bad = 0; m_good = 0; end
              else m_bad++;
            end
          end
        endcase
      end
    end
    e.d4 = m_g4; e.done4 = m_done4; e.serr4 = m_serr4;
    e.d8 = m_g8; e.done8 = m_done8; e.lk = (m_cst == 2); e.cerr = m_cerr; e.cnt = m_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("lfsr4", d4, e.d4);
    check_eq("bit4", bit4, e.d4[0]);
    check_eq("done4", done4, e.done4);
    check_eq("seed_err4", serr4, e.serr4);
    check_eq("lfsr8", d8, e.d8);
    check_eq("bit8", bit8, e.d8[0]);
    check_eq("done8", done8, e.done8);
    check_eq("seed_err8", serr8, 1'b0);
    check_eq("locked8", lk8, e.lk);
    check_eq("chk_err8", cerr8, e.cerr);
    check_eq("err_cnt8", cnt8, e.cnt);
  endtask

  logic [3:0] seq4 [5];
  logic       lock_seen;
  int         pulses;
  logic [7:0] held8;

  initial begin
    seq4[0] = 4'h1; seq4[1] = 4'h3; seq4[2] = 4'h7; seq4[3] = 4'hE; seq4[4] = 4'hD;
    lock_seen = 1'b0;

    // Reset must win over every other input.
    en4 = 1'b1; en8 = 1'b1; cv8 = 1'b1; sdv4 = 1'b1; sd4 = 4'h5;
    step();
    step();
    check_eq("rst_state", {d4, done4, serr4, d8, lk8, cnt8}, '0);
    sdv4 = 1'b0;
    rst  = 1'b0;

    // Free-running generators; dut8 output looped into its checker.
    for (int i = 0; i < 1000; i++) begin
      step();
      if (i < 5) check_eq("seq4", d4, seq4[i]);
      if (i == 14) check_eq("done4_step15", {done4, d4}, 5'h10);
      if (!lock_seen && lk8) begin
        lock_seen = 1'b1;
        check_eq("lock_at_bit", i + 1, 24);
      end
    end
    check_eq("lock_seen", lock_seen, 1'b1);
    check_eq("loop_err_cnt", cnt8, 0);

    // Seed load with enable high: no step, then Done after a full period.
    sdv4 = 1'b1; sd4 = 4'h6;
    step();
    sdv4 = 1'b0;
    check_eq("load4", {done4, d4}, 5'h06);
    for (int i = 0; i < 15; i++) step();
    check_eq("done_after_15", {done4, d4}, 5'h16);
    sdv4 = 1'b1; sd4 = 4'hF;
    step();
    sdv4 = 1'b0;
    check_eq("lockup_seed", {serr4, d4}, 5'h10);
    step();
    check_eq("seed_err_one_pulse", serr4, 1'b0);

    // One corrupted bit: flagged itself, then once at each of the four taps it reaches.
    pulses = 0;
    mode8 = 1;
    step();
    mode8 = 0;
    pulses += int'(cerr8);
    for (int i = 0; i < 20; i++) begin
      step();
      pulses += int'(cerr8);
    end
    check_eq("flip_pulses", pulses, 5);
    check_eq("flip_cnt", cnt8, 5);
    check_eq("flip_lock_held", lk8, 1'b1);

    // Always-wrong bits: lock drops on the 4th, count then freezes.
    mode8 = 2;
    for (int i = 0; i < 3; i++) step();
    check_eq("lock_before_loss", lk8, 1'b1);
    step();
    check_eq("lock_lost", lk8, 1'b0);
    check_eq("cnt_at_loss", cnt8, 9);
    for (int i = 0; i < 6; i++) step();
    check_eq("cnt_frozen", cnt8, 9);

    // Repeated relock and loss drives the 4-bit counter into saturation.
    for (int k = 0; k < 3; k++) begin
      mode8 = 0;
      for (int i = 0; i < 40; i++) step();
      check_eq("relock", lk8, 1'b1);
      mode8 = 2;
      for (int i = 0; i < 4; i++) step();
    end
    check_eq("cnt_saturated", cnt8, 15);

    // Valid gap freezes checker; enable low holds generator.
    mode8 = 0;
    for (int i = 0; i < 40; i++) step();
    held8 = m_g8;
    cv8 = 1'b0; en8 = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check_eq("gap_lfsr_held", d8, held8);
    check_eq("gap_lock_held", lk8, 1'b1);
    cv8 = 1'b1; en8 = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check_eq("post_gap_lock", lk8, 1'b1);
    check_eq("post_gap_cnt", cnt8, 15);

    // Reset mid-lock and mid-sequence.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("midrst_state", {d4, done4, serr4, d8, lk8, cerr8, cnt8}, '0);
    for (int i = 0; i < 30; i++) step();
    check_eq("relock_after_rst", lk8, 1'b1);
    check_eq("idle_chk4", {lk4, cerr4, cnt4}, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
